// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MISC-V instruction fetch stage (PC, imem handshake, IR); FETCH_PERF_CNT_EN adds fetch_wait_cnt
module instr_fetch #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [15:0]       instr_out,
  output logic [2:0]        opcode,
  output logic [3:0]        func,
  output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [15:0]       ir_q, ir_d;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      pc_out_q   <= '0;
      ir_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      pc_out_q   <= pc_out_d;
      ir_q       <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    pc_out_d   = pc_out_q;
    ir_d       = ir_q;
    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // An unfinished request must keep its address, so drain it first.
          if (imem_ready) begin
            req_addr_d = redirect_pc;
            state_d    = S_REQ;
          end else begin
            state_d    = S_DRAIN;
          end
        end else if (imem_ready) begin
          ir_d     = imem_rdata;
          pc_out_d = req_addr_q;
          pc_d     = pc_q + ADDR_W'(1);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = S_REQ;
        end else if (!stall) begin
          req_addr_d = pc_q;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (imem_ready) begin
          req_addr_d = pc_q;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // The request is masked while reset is held so memory never sees a stale fetch.
  assign imem_req    = !reset && (state_q != S_ISSUE);
  assign imem_addr   = req_addr_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign instr_out   = ir_q;
  assign opcode      = ir_q[15:13];
  assign func        = ir_q[3:0];
  assign pc_out      = pc_out_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] wait_cnt_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (imem_req && !imem_ready && (wait_cnt_q != 32'hFFFF_FFFF)) begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign fetch_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the MISC-V core: owns the program counter, runs a request/ready handshake with instruction memory, and holds the fetched 16-bit instruction in an instruction register. It sits directly upstream of the control unit. It drives the `opcode`/`func` fields the control unit samples on `CLK`, plus a valid flag and the instruction's PC for the execute stage.

## Interface
- `ADDR_W`, 16, PC / instruction-memory word-address width
- `RESET_PC`, 0, PC value loaded on reset
- `CLK`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  ADDR_W  word address of outstanding request
- `imem_ready`  in  1  memory has `imem_rdata` valid this cycle, completing the request
- `imem_rdata`  in  16  instruction word
- `stall`  in  1  downstream not ready; hold current instruction
- `redirect`  in  1  branch/jump taken; refetch from `redirect_pc`
- `redirect_pc`  in  ADDR_W  new PC
- `instr_valid`  out  1  `instr_out`/`opcode`/`func`/`pc_out` valid
- `instr_out`  out  16  instruction register
- `opcode`  out  3  `instr_out[15:13]`
- `func`  out  4  `instr_out[3:0]`
- `pc_out`  out  ADDR_W  address of instruction in `instr_out`

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_addr`: address of the outstanding request, drives `imem_addr`.
  - IR: `instr_out`.
  - `pc_out`.
  - State.
- States:
  - **REQ**: `imem_req`=1, `imem_addr`=`req_addr`.
  - **ISSUE**: `instr_valid`=1, `imem_req`=0.
  - **DRAIN**: `imem_req`=1, response will be discarded.
- REQ:
  - On `imem_ready`=1, capture `imem_rdata` into IR, `pc_out`<=`req_addr`, `pc`<=`pc`+1, and go to ISSUE.
  - Otherwise stay in REQ; `req_addr` stays stable.
- ISSUE:
  - `stall`=1: stay, IR and `pc_out` held.
  - `stall`=0: `req_addr`<=`pc` and go to REQ.
- `redirect`=1 has priority over `stall` and `imem_ready`. `pc`<=`redirect_pc`, `instr_valid`<=0, and the next state is:
  - In ISSUE, or in REQ with `imem_ready`=1 the same cycle: go to REQ with `req_addr`<=`redirect_pc`; the returned data is discarded.
  - In REQ with `imem_ready`=0: go to DRAIN. The request stays asserted at the old address until ready; then `req_addr`<=`pc` and go to REQ. Data is discarded.
  - In DRAIN: update `pc` only; remain in DRAIN.
- `opcode` and `func` are slices of IR, so they change only when IR loads.
- PC arithmetic is modulo 2^ADDR_W: all-ones + 1 wraps to 0.

## Timing
- While `reset`=1, asynchronously:
  - `pc`=`req_addr`=RESET_PC, state=REQ.
  - `instr_valid`=0, `instr_out`=0, `pc_out`=0.
  - `imem_req`=0. It is forced low during reset and goes to 1 on the first cycle after release.
- Reset mid-transaction abandons the request; no response is captured afterwards unless a new request is issued.
- Fetch latency: a zero-wait memory (`imem_ready` in the first REQ cycle) gives `instr_valid` the cycle after. With N wait cycles, `instr_valid` rises N+1 cycles after REQ entry.
- Throughput is at most one instruction per 2 cycles: REQ then ISSUE.
- `instr_valid` is high for exactly one cycle per instruction unless `stall` extends it.
- The control unit samples `opcode`/`func` on the edge ending the ISSUE cycle.
- Handshake: while `imem_req`=1 and `imem_ready`=0, `imem_addr` must not change, even across a redirect.

## Configuration
- `FETCH_PERF_CNT_EN`:
  - When defined, adds output `fetch_wait_cnt` (32 bits). It increments each cycle with `imem_req`=1 and `imem_ready`=0, saturates at all-ones, and is reset to 0.
  - When undefined, neither the port nor the counter exists. All other behaviour is identical.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning `16'h2003` at address 0:
  - Required: `imem_req`=1, `imem_addr`=0 at cycle 1; `instr_valid`=1, `opcode`=1, `func`=3, `pc_out`=0 at cycle 2; next request addr=1 at cycle 3.
- Memory with 3 wait cycles:
  - Required: `imem_addr` constant for 4 REQ cycles, `instr_valid` one cycle later.
  - If defined, `fetch_wait_cnt`=3.
- `stall`=1 for 5 cycles in ISSUE:
  - Required: `instr_valid`, `instr_out` and `pc_out` held for 6 cycles, `imem_req`=0 throughout.
- `redirect`=1, `redirect_pc`=`16'h0040` while in REQ with memory not ready:
  - Required: DRAIN keeps the old addr until ready, the response is discarded (`instr_valid` stays 0), then a request to `16'h0040` is issued.
- `redirect` and `stall` together in ISSUE:
  - Required: `instr_valid`=0 next cycle, request to `redirect_pc`.
- PC wrap with RESET_PC=`16'hFFFF`:
  - Required: first fetch at FFFF, `pc_out`=FFFF, next request at 0000.
- Assert `reset` mid-REQ:
  - Required: outputs clear immediately, `imem_req`=0 during reset, fetch restarts at RESET_PC.
